// File: rtl/pipe_stage_ctrl.sv
// Valid/ready controller for one pipeline stage with a main bank and a skid bank.
// Handles flush squash and keeps a saturating count of downstream stall cycles.
module pipe_stage_ctrl #(
  parameter int unsigned LENGTH = 223,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [LENGTH-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LENGTH-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cycles
);

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StTwo   = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [LENGTH-1:0]   main_q, main_d;
  logic [LENGTH-1:0]   skid_q, skid_d;
  logic [CNT_W-1:0]    stall_q, stall_d;
  logic                main_en, skid_en;
  logic                in_fire, out_fire;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // State register and data banks.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StEmpty;
      main_q  <= '0;
      skid_q  <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      stall_q <= stall_d;
    end
  end

  // Next-state and bank-enable logic.
  always_comb begin
    state_d = state_q;
    main_en = 1'b0;
    skid_en = 1'b0;
    unique case (state_q)
      StEmpty: begin
        if (in_fire) begin
          main_en = 1'b1;
          state_d = StOne;
        end
      end
      StOne: begin
        if (in_fire && out_fire) begin
          main_en = 1'b1;
        end else if (in_fire) begin
          skid_en = 1'b1;
          state_d = StTwo;
        end else if (out_fire) begin
          state_d = StEmpty;
        end
      end
      StTwo: begin
        if (out_fire) begin
          main_en = 1'b1;
          state_d = StOne;
        end
      end
      default: state_d = StEmpty;
    endcase
    // Flush drops validity only; bank contents are left as they were.
    if (flush) begin
      state_d = StEmpty;
      main_en = 1'b0;
      skid_en = 1'b0;
    end
  end

  always_comb begin
    main_d = main_q;
    skid_d = skid_q;
    if (main_en) main_d = (state_q == StTwo) ? skid_q : in_data;
    if (skid_en) skid_d = in_data;
  end

  always_comb begin
    stall_d = stall_q;
    if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) stall_d = stall_q + 1'b1;
  end

  // Outputs depend on registered state only.
  always_comb begin
    out_valid    = (state_q != StEmpty);
    in_ready     = (state_q != StTwo);
    occupancy    = state_q;
    out_data     = main_q;
    stall_cycles = stall_q;
  end

endmodule

// File: tb/tb_pipe_stage_ctrl.sv
// Directed self-checking bench for pipe_stage_ctrl.
module tb_pipe_stage_ctrl;

  localparam int unsigned L = 223;

  logic         clk = 1'b0;
  logic         reset, flush, in_valid, out_ready;
  logic         in_ready, out_valid;
  logic [L-1:0] in_data, out_data;
  logic [1:0]   occupancy;
  logic [15:0]  stall_cycles;

  logic         s_in_valid, s_out_ready, s_in_ready, s_out_valid;
  logic [7:0]   s_out_data;
  logic [1:0]   s_occupancy;
  logic [3:0]   s_stall;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pipe_stage_ctrl #(.LENGTH(L), .CNT_W(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .occupancy   (occupancy),
    .stall_cycles(stall_cycles)
  );

  pipe_stage_ctrl #(.LENGTH(8), .CNT_W(4)) dut_sat (
    .clk         (clk),
    .reset       (reset),
    .flush       (1'b0),
    .in_valid    (s_in_valid),
    .in_ready    (s_in_ready),
    .in_data     (8'h5A),
    .out_valid   (s_out_valid),
    .out_ready   (s_out_ready),
    .out_data    (s_out_data),
    .occupancy   (s_occupancy),
    .stall_cycles(s_stall)
  );

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    s_in_valid = 1'b0; s_out_ready = 1'b0;
    step(); step();
    reset = 1'b0;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_occupancy", occupancy, 0);
    check("rst_out_data", out_data, 0);
    check("rst_stall", stall_cycles, 0);

    // Streaming at full throughput.
    out_ready = 1'b1; in_valid = 1'b1;
    in_data = 'h11; step();
    check("stream_d0", out_data, 'h11); check("stream_occ0", occupancy, 1);
    check("stream_rdy0", in_ready, 1);
    in_data = 'h22; step();
    check("stream_d1", out_data, 'h22); check("stream_occ1", occupancy, 1);
    check("stream_rdy1", in_ready, 1);
    in_data = 'h33; step();
    check("stream_d2", out_data, 'h33); check("stream_occ2", occupancy, 1);
    in_valid = 1'b0; step();
    check("stream_drain_occ", occupancy, 0);
    check("stream_stall", stall_cycles, 0);

    // Backpressure fills the skid bank.
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 'hA; step();
    check("bp_occ1", occupancy, 1); check("bp_a", out_data, 'hA);
    in_data = 'hB; step();
    check("bp_occ2", occupancy, 2); check("bp_rdy0", in_ready, 0);
    check("bp_a_hold", out_data, 'hA); check("bp_stall1", stall_cycles, 1);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_a_stable", out_data, 'hA);
    end
    check("bp_stall4", stall_cycles, 4);
    check("bp_rdy_held", in_ready, 0);
    out_ready = 1'b1; step();
    check("bp_b", out_data, 'hB); check("bp_occ_after1", occupancy, 1);
    check("bp_rdy_back", in_ready, 1);
    step();
    check("bp_occ_after2", occupancy, 0); check("bp_stall_final", stall_cycles, 4);

    // Simultaneous in/out while holding one entry.
    out_ready = 1'b0; in_valid = 1'b1; in_data = 'h5; step();
    check("sim_main5", out_data, 'h5);
    out_ready = 1'b1; in_data = 'h6; step();
    check("sim_main6", out_data, 'h6); check("sim_occ", occupancy, 1);
    check("sim_skid_untouched", dut.skid_q, 'hB);
    in_valid = 1'b0; step();
    check("sim_drain", occupancy, 0);

    // Flush while full, with a payload offered.
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 'h8; step();
    in_data = 'h9; step();
    check("fl_occ2", occupancy, 2);
    flush = 1'b1; in_data = 'hC; step();
    check("fl_occ", occupancy, 0); check("fl_out_valid", out_valid, 0);
    check("fl_in_ready", in_ready, 1); check("fl_stall_kept", stall_cycles, 6);
    check("fl_bank_kept", out_data, 'h8);
    step();
    check("fl_in_fire_dropped", occupancy, 0);
    check("fl_no_c", out_data, 'h8);
    flush = 1'b0; out_ready = 1'b1; in_data = 'hD; step();
    check("fl_d", out_data, 'hD); check("fl_d_occ", occupancy, 1);
    in_valid = 1'b0; step();
    check("fl_d_drain", occupancy, 0);

    // Reset beats flush mid-operation.
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 'hE; step();
    in_data = 'hF; step();
    check("rf_occ2", occupancy, 2); check("rf_stall7", stall_cycles, 7);
    reset = 1'b1; flush = 1'b1; in_valid = 1'b0; step();
    check("rf_data", out_data, 0); check("rf_occ", occupancy, 0);
    check("rf_stall", stall_cycles, 0); check("rf_in_ready", in_ready, 1);
    reset = 1'b0; flush = 1'b0;

    // Saturation on the narrow-counter instance.
    s_in_valid = 1'b1; step();
    s_in_valid = 1'b0;
    check("sat_occ", s_occupancy, 1);
    for (int i = 0; i < 10; i++) step();
    check("sat_10", s_stall, 10);
    for (int i = 0; i < 10; i++) step();
    check("sat_15", s_stall, 15);
    check("sat_valid", s_out_valid, 1);
    check("sat_data", s_out_data, 'h5A);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
